// File: rtl/tb_writer.sv
// Viterbi survivor-memory write side plus sliding-window traceback segment scheduler.
// Optional feature macro: TB_WRITER_ZERO_TAIL_EN (final segment starts from state 0).
module tb_writer #(
  parameter int W_TB_LEN = 6,
  parameter int W_DEC    = 64
) (
  input  logic                clk_i,
  input  logic                rst_sync_i,
  input  logic [1:0]          register_num_i,
  input  logic                frame_start_i,
  input  logic [W_TB_LEN:0]   tb_len_i,
  input  logic                dec_valid_i,
  output logic                dec_ready_o,
  input  logic [W_DEC-1:0]    dec_bits_i,
  input  logic                dec_last_i,
  input  logic [5:0]          best_state_i,
  output logic                tb_wr_o,
  output logic [W_TB_LEN-1:0] tb_waddr_o,
  output logic [W_DEC-1:0]    tb_wdata_o,
  input  logic                tb_busy_i,
  output logic                segment_start_o,
  output logic [W_TB_LEN-1:0] tb_start_addr_o,
  output logic [W_TB_LEN:0]   tb_len_o,
  output logic [5:0]          start_state_index_o,
  output logic                decodeing_end_o,
  output logic                frame_done_o
);

  typedef enum logic [2:0] {IDLE, FILL, RUN, SEG, FLUSH} state_t;

  state_t              state_reg;
  logic [W_TB_LEN-1:0] wr_addr_reg;
  logic [W_TB_LEN:0]   written_reg;
  logic [W_TB_LEN:0]   emitted_reg;
  logic [W_TB_LEN-1:0] since_seg_reg;
  logic [W_TB_LEN:0]   d_reg;
  logic [1:0]          reg_num_reg;
  logic [W_TB_LEN-1:0] req_addr_reg;
  logic [W_TB_LEN:0]   req_len_reg;
  logic [5:0]          req_state_reg;
  logic                req_end_reg;

  logic [W_DEC-1:0]    dec_mask;
  logic [W_TB_LEN-1:0] half;
  logic [W_TB_LEN:0]   written_inc;
  logic [W_TB_LEN:0]   last_len;
  logic [W_TB_LEN-1:0] since_inc;
  logic [5:0]          final_state;
  logic                wr_fire;
  logic                issue_ok;

  // Bits above the active state count are forced to zero before storage.
  genvar gi;
  generate
    for (gi = 0; gi < W_DEC; gi++) begin : g_mask
      assign dec_mask[gi] = (32'(gi) < (32'd64 >> reg_num_reg));
    end
  endgenerate

  assign half        = d_reg[W_TB_LEN:1];
  assign written_inc = written_reg + (W_TB_LEN+1)'(1);
  assign since_inc   = since_seg_reg + W_TB_LEN'(1);
  assign last_len    = written_inc - emitted_reg;
  assign wr_fire     = dec_valid_i & dec_ready_o & ~frame_start_i;
  // Pulse only after the triggering write has reached the RAM, never back-to-back.
  assign issue_ok    = ~tb_busy_i & ~segment_start_o;

`ifdef TB_WRITER_ZERO_TAIL_EN
  assign final_state = 6'd0;
`else
  assign final_state = best_state_i;
`endif

  always_ff @(posedge clk_i) begin
    if (rst_sync_i) begin
      state_reg           <= IDLE;
      dec_ready_o         <= 1'b0;
      wr_addr_reg         <= '0;
      written_reg         <= '0;
      emitted_reg         <= '0;
      since_seg_reg       <= '0;
      d_reg               <= '0;
      reg_num_reg         <= '0;
      req_addr_reg        <= '0;
      req_len_reg         <= '0;
      req_state_reg       <= '0;
      req_end_reg         <= 1'b0;
      tb_wr_o             <= 1'b0;
      tb_waddr_o          <= '0;
      tb_wdata_o          <= '0;
      segment_start_o     <= 1'b0;
      tb_start_addr_o     <= '0;
      tb_len_o            <= '0;
      start_state_index_o <= '0;
      decodeing_end_o     <= 1'b0;
      frame_done_o        <= 1'b0;
    end else begin
      tb_wr_o         <= wr_fire;
      segment_start_o <= 1'b0;
      frame_done_o    <= 1'b0;
      if (wr_fire) begin
        tb_waddr_o  <= wr_addr_reg;
        tb_wdata_o  <= dec_bits_i & dec_mask;
        wr_addr_reg <= wr_addr_reg + W_TB_LEN'(1);
      end

      if (frame_start_i) begin
        // Start or abort-and-restart; the write address deliberately survives.
        state_reg     <= FILL;
        dec_ready_o   <= 1'b1;
        d_reg         <= tb_len_i;
        reg_num_reg   <= register_num_i;
        written_reg   <= '0;
        emitted_reg   <= '0;
        since_seg_reg <= '0;
        req_end_reg   <= 1'b0;
      end else begin
        case (state_reg)
          FILL, RUN: begin
            if (wr_fire) begin
              written_reg  <= written_inc;
              req_addr_reg <= wr_addr_reg;
              if (state_reg == RUN) since_seg_reg <= since_inc;
              if (dec_last_i) begin
                req_len_reg   <= last_len;
                req_state_reg <= final_state;
                req_end_reg   <= 1'b1;
                state_reg     <= FLUSH;
                dec_ready_o   <= 1'b0;
              end else if ((state_reg == FILL) ? (written_inc == d_reg)
                                               : (since_inc == half)) begin
                req_len_reg   <= d_reg;
                req_state_reg <= best_state_i;
                req_end_reg   <= 1'b0;
                state_reg     <= SEG;
                dec_ready_o   <= 1'b0;
              end
            end
          end
          SEG, FLUSH: begin
            if (issue_ok) begin
              segment_start_o     <= 1'b1;
              tb_start_addr_o     <= req_addr_reg;
              tb_len_o            <= req_len_reg;
              start_state_index_o <= req_state_reg;
              decodeing_end_o     <= req_end_reg;
              if (state_reg == FLUSH) begin
                state_reg    <= IDLE;
                frame_done_o <= 1'b1;
              end else begin
                emitted_reg   <= emitted_reg + {1'b0, half};
                since_seg_reg <= '0;
                state_reg     <= RUN;
                dec_ready_o   <= 1'b1;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_tb_writer.sv
// Self-checking bench for tb_writer: randomized frames against an arithmetic segment-schedule model.
module tb_tb_writer;

  logic        clk_i = 1'b0;
  logic        rst_sync_i = 1'b1;
  logic [1:0]  register_num_i = '0;
  logic        frame_start_i = 1'b0;
  logic [6:0]  tb_len_i = '0;
  logic        dec_valid_i = 1'b0;
  logic        dec_ready_o;
  logic [63:0] dec_bits_i = '0;
  logic        dec_last_i = 1'b0;
  logic [5:0]  best_state_i = '0;
  logic        tb_wr_o;
  logic [5:0]  tb_waddr_o;
  logic [63:0] tb_wdata_o;
  logic        tb_busy_i = 1'b0;
  logic        segment_start_o;
  logic [5:0]  tb_start_addr_o;
  logic [6:0]  tb_len_o;
  logic [5:0]  start_state_index_o;
  logic        decodeing_end_o;
  logic        frame_done_o;

  tb_writer #(.W_TB_LEN(6), .W_DEC(64)) dut (
    .clk_i(clk_i), .rst_sync_i(rst_sync_i), .register_num_i(register_num_i),
    .frame_start_i(frame_start_i), .tb_len_i(tb_len_i), .dec_valid_i(dec_valid_i),
    .dec_ready_o(dec_ready_o), .dec_bits_i(dec_bits_i), .dec_last_i(dec_last_i),
    .best_state_i(best_state_i), .tb_wr_o(tb_wr_o), .tb_waddr_o(tb_waddr_o),
    .tb_wdata_o(tb_wdata_o), .tb_busy_i(tb_busy_i), .segment_start_o(segment_start_o),
    .tb_start_addr_o(tb_start_addr_o), .tb_len_o(tb_len_o),
    .start_state_index_o(start_state_index_o), .decodeing_end_o(decodeing_end_o),
    .frame_done_o(frame_done_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct { logic [5:0] a; logic [63:0] d; } wr_t;
  typedef struct { logic [5:0] a; logic [6:0] len; logic [5:0] st; logic e; logic done; } seg_t;

  wr_t  obs_w[$], exp_w[$];
  seg_t obs_s[$], exp_s[$];
  int   n_cmp = 0, n_bad = 0;
  int   done_cnt = 0, done_base = 0;
  int   model_addr = 0;
  int   f_d, f_rn, f_base, f_n;
  int   f_best[$];
  int   force_idx = -1, force_val = 0;
  bit   all_ones = 1'b0;
  wr_t  mon_w;
  seg_t mon_s;

  always @(negedge clk_i) begin
    if (tb_wr_o) begin
      mon_w.a = tb_waddr_o; mon_w.d = tb_wdata_o;
      obs_w.push_back(mon_w);
    end
    if (segment_start_o) begin
      mon_s.a = tb_start_addr_o; mon_s.len = tb_len_o; mon_s.st = start_state_index_o;
      mon_s.e = decodeing_end_o; mon_s.done = frame_done_o;
      obs_s.push_back(mon_s);
    end
    if (frame_done_o) done_cnt++;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] mask_of(input int rn);
    int n;
    n = 64 >> rn;
    return (n == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << n) - 64'd1);
  endfunction

  task automatic start_frame(input int d, input int rn, input bit collide);
    @(negedge clk_i);
    frame_start_i = 1'b1; tb_len_i = 7'(d); register_num_i = 2'(rn);
    dec_valid_i = collide; dec_bits_i = {$urandom, $urandom}; dec_last_i = 1'b0;
    @(negedge clk_i);
    frame_start_i = 1'b0; dec_valid_i = 1'b0;
    f_d = d; f_rn = rn; f_base = model_addr; f_n = 0; f_best.delete();
    done_base = done_cnt;
    check("ready_after_start", 64'(dec_ready_o), 64'd1);
  endtask

  task automatic drive_writes(input int n, input bit with_last, input bit rand_busy, input bit rand_gap);
    int done = 0;
    int cyc = 0;
    int best;
    logic [63:0] bits;
    wr_t w;
    while (done < n && cyc < 3000) begin
      @(negedge clk_i);
      cyc++;
      if (rand_busy) tb_busy_i = ($urandom_range(0, 3) == 0);
      if (rand_gap && $urandom_range(0, 3) == 0) begin
        dec_valid_i = 1'b0; dec_last_i = 1'b0;
      end else begin
        bits = all_ones ? 64'hFFFF_FFFF_FFFF_FFFF : {$urandom, $urandom};
        best = (f_n == force_idx) ? force_val : int'($urandom_range(0, 63));
        dec_valid_i = 1'b1; dec_bits_i = bits; best_state_i = 6'(best);
        dec_last_i = with_last && (done == n - 1);
        if (dec_ready_o) begin
          w.a = 6'(model_addr); w.d = bits & mask_of(f_rn);
          exp_w.push_back(w);
          f_best.push_back(best);
          f_n++; done++;
          model_addr = (model_addr + 1) % 64;
        end
      end
    end
    @(negedge clk_i);
    dec_valid_i = 1'b0; dec_last_i = 1'b0;
    if (rand_busy) tb_busy_i = 1'b0;
    check("drive_budget", 64'(done), 64'(n));
  endtask

  // Expected schedule: full windows at writes D, D+H, D+2H, ... strictly before the last write.
  task automatic finish_frame();
    int cyc = 0;
    int h, k, nseg, m;
    seg_t s;
    tb_busy_i = 1'b0;
    while (done_cnt == done_base && cyc < 500) begin
      @(negedge clk_i); #1; cyc++;
    end
    check("frame_done_seen", 64'(done_cnt), 64'(done_base + 1));
    check("idle_ready", 64'(dec_ready_o), 64'd0);
    h = f_d / 2; k = f_d; nseg = 0;
    while (k < f_n) begin
      s.a = 6'((f_base + k - 1) % 64); s.len = 7'(f_d); s.st = 6'(f_best[k-1]);
      s.e = 1'b0; s.done = 1'b0;
      exp_s.push_back(s);
      nseg++; k += h;
    end
    s.a = 6'((f_base + f_n - 1) % 64); s.len = 7'(f_n - nseg * h);
`ifdef TB_WRITER_ZERO_TAIL_EN
    s.st = 6'd0;
`else
    s.st = 6'(f_best[f_n-1]);
`endif
    s.e = 1'b1; s.done = 1'b1;
    exp_s.push_back(s);
    check("seg_count", 64'(obs_s.size()), 64'(exp_s.size()));
    m = (obs_s.size() < exp_s.size()) ? obs_s.size() : exp_s.size();
    for (int i = 0; i < m; i++) begin
      check("seg_addr", 64'(obs_s[i].a), 64'(exp_s[i].a));
      check("seg_len", 64'(obs_s[i].len), 64'(exp_s[i].len));
      check("seg_state", 64'(obs_s[i].st), 64'(exp_s[i].st));
      check("seg_end", 64'(obs_s[i].e), 64'(exp_s[i].e));
      check("seg_done", 64'(obs_s[i].done), 64'(exp_s[i].done));
    end
    check("wr_count", 64'(obs_w.size()), 64'(exp_w.size()));
    m = (obs_w.size() < exp_w.size()) ? obs_w.size() : exp_w.size();
    for (int i = 0; i < m; i++) begin
      check("wr_addr", 64'(obs_w[i].a), 64'(exp_w[i].a));
      check("wr_data", obs_w[i].d, exp_w[i].d);
    end
  endtask

  task automatic clear_q();
    obs_w.delete(); exp_w.delete(); obs_s.delete(); exp_s.delete();
  endtask

  initial begin
    int d, rn, n;
    repeat (3) @(negedge clk_i);
    check("rst_ready", 64'(dec_ready_o), 64'd0);
    check("rst_wr", 64'(tb_wr_o), 64'd0);
    check("rst_waddr", 64'(tb_waddr_o), 64'd0);
    check("rst_wdata", tb_wdata_o, 64'd0);
    check("rst_seg", 64'(segment_start_o), 64'd0);
    check("rst_saddr", 64'(tb_start_addr_o), 64'd0);
    check("rst_len", 64'(tb_len_o), 64'd0);
    check("rst_state", 64'(start_state_index_o), 64'd0);
    check("rst_end", 64'(decodeing_end_o), 64'd0);
    check("rst_done", 64'(frame_done_o), 64'd0);
    rst_sync_i = 1'b0;
    @(negedge clk_i);
    check("idle_ready0", 64'(dec_ready_o), 64'd0);

    // D=8, 20-write frame; best state 5 on the 8th write
    start_frame(8, 0, 1'b0);
    force_idx = 7; force_val = 5;
    drive_writes(20, 1'b1, 1'b0, 1'b0);
    force_idx = -1;
    finish_frame();
    if (obs_s.size() > 0) begin
      check("first_seg_addr", 64'(obs_s[0].a), 64'd7);
      check("first_seg_len", 64'(obs_s[0].len), 64'd8);
      check("first_seg_state", 64'(obs_s[0].st), 64'd5);
      check("first_seg_end", 64'(obs_s[0].e), 64'd0);
    end
    clear_q();

    // 16-state masking with all-ones decisions
    start_frame(8, 2, 1'b0);
    all_ones = 1'b1;
    drive_writes(6, 1'b1, 1'b0, 1'b0);
    all_ones = 1'b0;
    finish_frame();
    if (obs_w.size() > 0) check("mask16", obs_w[0].d, 64'h0000_0000_0000_FFFF);
    clear_q();

    // Busy stall holds the pending segment and the input
    start_frame(8, 0, 1'b0);
    tb_busy_i = 1'b1;
    drive_writes(8, 1'b0, 1'b0, 1'b0);
    repeat (20) begin
      @(negedge clk_i); #1;
      check("stall_ready", 64'(dec_ready_o), 64'd0);
    end
    check("stall_nopulse", 64'(obs_s.size()), 64'd0);
    tb_busy_i = 1'b0;
    @(negedge clk_i); #1;
    check("release_pulse", 64'(obs_s.size()), 64'd1);
    drive_writes(4, 1'b1, 1'b0, 1'b0);
    finish_frame();
    clear_q();

    // Abort mid-frame; the colliding write with frame_start is discarded
    start_frame(8, 0, 1'b0);
    drive_writes(5, 1'b0, 1'b1, 1'b1);
    start_frame(4, 1, 1'b1);
    drive_writes(10, 1'b1, 1'b1, 1'b1);
    finish_frame();
    clear_q();

    // D=32, 70 writes: address wrap and window addressing
    start_frame(32, 0, 1'b0);
    drive_writes(70, 1'b1, 1'b1, 1'b0);
    finish_frame();
    clear_q();

    for (int r = 0; r < 6; r++) begin
      d  = 2 * int'($urandom_range(2, 16));
      rn = int'($urandom_range(0, 3));
      n  = int'($urandom_range(1, 60));
      start_frame(d, rn, 1'b0);
      drive_writes(n, 1'b1, 1'b1, 1'b1);
      finish_frame();
      clear_q();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
